// File: rtl/dipsw_ctrl_pkg.sv
// Shared types and PIO register map for the DIP-switch poll controller.
package dipsw_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT_RD, S_INIT_WAIT, S_IDLE, S_RD_EDGE, S_WAIT_EDGE,
    S_CLR, S_RD_DATA, S_WAIT_DATA, S_CHECK
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/poll_timer.sv
// Loadable down-counter setting the poll cadence; holds at zero until reloaded.
module poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int TW = $clog2(POLL_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_cnt <= RELOAD;
    else if (i_load)              r_cnt <= RELOAD;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dipsw_poll_ctrl.sv
// Avalon-MM master that polls the DIP-switch PIO edge register, clears edges,
// reads live data and debounces it into a stable switch word plus change strobe.
module dipsw_poll_ctrl
  import dipsw_ctrl_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_POLLS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             poll_now,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] sw_value,
  output logic             sw_change,
  output logic [WIDTH-1:0] sw_change_mask,
  output logic             busy
);

  localparam int CW = $clog2(STABLE_POLLS + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_POLLS);

  state_e           r_state;
  logic [1:0]       r_addr;
  logic             r_cs;
  logic             r_wr_n;
  logic [WIDTH-1:0] r_value;
  logic             r_change;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;

  logic             w_zero;
  logic             w_go;
  logic             w_dec;
  logic [WIDTH-1:0] w_rd;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_unused;

  assign w_rd      = avm_readdata[WIDTH-1:0];
  assign w_unused  = ^avm_readdata[31:WIDTH];
  assign w_cnt_inc = r_cnt + 1'b1;
  // poll_now is only honoured in IDLE, so requests during a poll are dropped
  assign w_go  = (r_state == S_IDLE) && ((w_zero && enable) || poll_now);
  assign w_dec = (r_state == S_IDLE) && enable && !w_go;

  poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_go),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_INIT_RD;
      r_addr   <= ADDR_DATA;
      r_cs     <= 1'b0;
      r_wr_n   <= 1'b1;
      r_value  <= '0;
      r_change <= 1'b0;
      r_mask   <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
    end else begin
      r_change <= 1'b0;
      case (r_state)
        S_INIT_RD: begin
          r_addr  <= ADDR_DATA;
          r_cs    <= 1'b1;
          r_state <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          r_value <= w_rd;
          r_cand  <= w_rd;
          r_cnt   <= STABLE_MAX;
          r_cs    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_IDLE: if (w_go) begin
          r_addr  <= ADDR_EDGE;
          r_cs    <= 1'b1;
          r_state <= S_RD_EDGE;
        end
        S_RD_EDGE: r_state <= S_WAIT_EDGE;
        S_WAIT_EDGE: begin
          if (w_rd != '0) begin
            r_wr_n  <= 1'b0;
            r_state <= S_CLR;
          end else begin
            r_cs    <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        // clearing before the data read means later edges survive to the next poll
        S_CLR: begin
          r_wr_n  <= 1'b1;
          r_addr  <= ADDR_DATA;
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: r_state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          r_cand  <= w_rd;
          r_cnt   <= '0;
          r_cs    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_CHECK: begin
          if (r_cnt < STABLE_MAX) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == STABLE_MAX && r_cand != r_value) begin
              r_value  <= r_cand;
              r_mask   <= r_value ^ r_cand;
              r_change <= 1'b1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_INIT_RD;
      endcase
    end
  end

  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wr_n;
  assign avm_writedata  = '0;
  assign sw_value       = r_value;
  assign sw_change      = r_change;
  assign sw_change_mask = r_mask;
  assign busy           = (r_state != S_IDLE);

endmodule
